// File: rtl/user_obi_sample_mover.sv
// User-domain OBI manager: copies a programmed number of 32-bit words from a
// source to a destination address. Each word is one read followed by one
// write. Transfers can optionally be paced by a one-cycle sample tick.
module user_obi_sample_mover #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 1,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] src_addr_i,
    input  logic [AddrWidth-1:0] dst_addr_i,
    input  logic                 src_inc_i,
    input  logic                 dst_inc_i,
    input  logic [CntWidth-1:0]  count_i,
    input  logic                 pace_en_i,
    input  logic                 tick_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 overrun_o,
    output logic [CntWidth-1:0]  xfer_cnt_o,
    output logic                 obi_req_o,
    input  logic                 obi_gnt_i,
    output logic [AddrWidth-1:0] obi_addr_o,
    output logic                 obi_we_o,
    output logic [3:0]           obi_be_o,
    output logic [DataWidth-1:0] obi_wdata_o,
    output logic [IdWidth-1:0]   obi_aid_o,
    input  logic                 obi_rvalid_i,
    input  logic [DataWidth-1:0] obi_rdata_i,
    input  logic [IdWidth-1:0]   obi_rid_i,
    input  logic                 obi_err_i
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        RD_REQ,
        RD_RSP,
        WR_REQ,
        WR_RSP,
        DONE
    } state_e;

    state_e               state_q;
    logic [AddrWidth-1:0] src_q;
    logic [AddrWidth-1:0] dst_q;
    logic [AddrWidth-1:0] src_next;
    logic [AddrWidth-1:0] dst_next;
    logic                 src_inc_q;
    logic                 dst_inc_q;
    logic                 pace_q;
    logic                 tick_pending_q;
    logic [CntWidth-1:0]  rem_q;
    logic                 unused_inputs;

    // Word addresses after the current word completes; wrap silently.
    assign src_next = src_inc_q ? src_q + AddrWidth'(4) : src_q;
    assign dst_next = dst_inc_q ? dst_q + AddrWidth'(4) : dst_q;

    // Single outstanding transaction, so the ID is constant and rid is unchecked.
    assign obi_aid_o     = '0;
    assign unused_inputs = ^{src_addr_i[1:0], dst_addr_i[1:0], obi_rid_i};

    // Transfer FSM with registered status and OBI request outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            src_q          <= '0;
            dst_q          <= '0;
            src_inc_q      <= 1'b0;
            dst_inc_q      <= 1'b0;
            pace_q         <= 1'b0;
            tick_pending_q <= 1'b0;
            rem_q          <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
            overrun_o      <= 1'b0;
            xfer_cnt_o     <= '0;
            obi_req_o      <= 1'b0;
            obi_addr_o     <= '0;
            obi_we_o       <= 1'b0;
            obi_be_o       <= '0;
            obi_wdata_o    <= '0;
        end else begin
            done_o <= 1'b0;

            // A tick arriving while the engine is not waiting is queued one deep.
            if (busy_o && tick_i && (state_q != WAIT_TICK)) begin
                if (tick_pending_q) begin
                    overrun_o <= 1'b1;
                end
                tick_pending_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        src_q          <= {src_addr_i[AddrWidth-1:2], 2'b00};
                        dst_q          <= {dst_addr_i[AddrWidth-1:2], 2'b00};
                        src_inc_q      <= src_inc_i;
                        dst_inc_q      <= dst_inc_i;
                        pace_q         <= pace_en_i;
                        rem_q          <= count_i;
                        xfer_cnt_o     <= '0;
                        err_o          <= 1'b0;
                        overrun_o      <= 1'b0;
                        tick_pending_q <= 1'b0;
                        busy_o         <= 1'b1;
                        if (count_i == '0) begin
                            state_q <= DONE;
                            done_o  <= 1'b1;
                        end else if (pace_en_i) begin
                            state_q <= WAIT_TICK;
                        end else begin
                            state_q    <= RD_REQ;
                            obi_req_o  <= 1'b1;
                            obi_we_o   <= 1'b0;
                            obi_be_o   <= '1;
                            obi_addr_o <= {src_addr_i[AddrWidth-1:2], 2'b00};
                        end
                    end
                end

                WAIT_TICK: begin
                    if (tick_pending_q || tick_i) begin
                        // Consuming a pending tick while a fresh one arrives keeps the fresh one queued.
                        tick_pending_q <= tick_pending_q & tick_i;
                        state_q        <= RD_REQ;
                        obi_req_o      <= 1'b1;
                        obi_we_o       <= 1'b0;
                        obi_be_o       <= '1;
                        obi_addr_o     <= src_q;
                    end
                end

                RD_REQ: begin
                    if (obi_gnt_i) begin
                        obi_req_o <= 1'b0;
                        state_q   <= RD_RSP;
                    end
                end

                RD_RSP: begin
                    if (obi_rvalid_i) begin
                        obi_wdata_o <= obi_rdata_i;
                        if (obi_err_i) begin
                            err_o   <= 1'b1;
                            done_o  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q    <= WR_REQ;
                            obi_req_o  <= 1'b1;
                            obi_we_o   <= 1'b1;
                            obi_be_o   <= '1;
                            obi_addr_o <= dst_q;
                        end
                    end
                end

                WR_REQ: begin
                    if (obi_gnt_i) begin
                        obi_req_o <= 1'b0;
                        state_q   <= WR_RSP;
                    end
                end

                WR_RSP: begin
                    if (obi_rvalid_i) begin
                        if (obi_err_i) begin
                            err_o   <= 1'b1;
                            done_o  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            xfer_cnt_o <= xfer_cnt_o + CntWidth'(1);
                            src_q      <= src_next;
                            dst_q      <= dst_next;
                            rem_q      <= rem_q - CntWidth'(1);
                            if (rem_q == CntWidth'(1)) begin
                                done_o  <= 1'b1;
                                state_q <= DONE;
                            end else if (pace_q) begin
                                state_q <= WAIT_TICK;
                            end else begin
                                state_q    <= RD_REQ;
                                obi_req_o  <= 1'b1;
                                obi_we_o   <= 1'b0;
                                obi_be_o   <= '1;
                                obi_addr_o <= src_next;
                            end
                        end
                    end
                end

                DONE: begin
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_user_obi_sample_mover.sv
// Bench for user_obi_sample_mover: an OBI subordinate model answers requests,
// a monitor checks every granted transaction against a queue of expected
// transactions computed from the transfer parameters.
module tb_user_obi_sample_mover;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic        src_inc;
    logic        dst_inc;
    logic [15:0] count;
    logic        pace_en;
    logic        tick;
    logic        busy;
    logic        done;
    logic        err;
    logic        overrun;
    logic [15:0] xfer_cnt;
    logic        obi_req;
    logic        obi_gnt;
    logic [31:0] obi_addr;
    logic        obi_we;
    logic [3:0]  obi_be;
    logic [31:0] obi_wdata;
    logic [0:0]  obi_aid;
    logic        obi_rvalid;
    logic [31:0] obi_rdata;
    logic [0:0]  obi_rid;
    logic        obi_err;
    logic [90:0] all_outs;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   last_tick = 0;
    int   tick_period = 0;
    int   tcnt = 0;
    int   rd_stall = 0;
    int   wr_stall = 0;
    bit   rsp_random = 0;
    bit   chk_pace = 0;
    bit   late_rsp = 0;
    int   err_read = -1;
    int   rd_idx = 0;
    logic [31:0] salt = 32'h0;
    txn_t exp_q[$];

    assign all_outs = {obi_req, obi_we, obi_be, obi_addr, obi_wdata, obi_aid,
                       busy, done, err, overrun, xfer_cnt};

    user_obi_sample_mover #(
        .AddrWidth(32),
        .DataWidth(32),
        .IdWidth  (1),
        .CntWidth (16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .src_addr_i  (src_addr),
        .dst_addr_i  (dst_addr),
        .src_inc_i   (src_inc),
        .dst_inc_i   (dst_inc),
        .count_i     (count),
        .pace_en_i   (pace_en),
        .tick_i      (tick),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .overrun_o   (overrun),
        .xfer_cnt_o  (xfer_cnt),
        .obi_req_o   (obi_req),
        .obi_gnt_i   (obi_gnt),
        .obi_addr_o  (obi_addr),
        .obi_we_o    (obi_we),
        .obi_be_o    (obi_be),
        .obi_wdata_o (obi_wdata),
        .obi_aid_o   (obi_aid),
        .obi_rvalid_i(obi_rvalid),
        .obi_rdata_i (obi_rdata),
        .obi_rid_i   (obi_rid),
        .obi_err_i   (obi_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Contents of the k-th word read during a transfer.
    function automatic logic [31:0] mem_word(input logic [31:0] s, input int i);
        return s ^ (32'(i) * 32'h9E3779B9) ^ (32'(i) << 20);
    endfunction

    // Sample strobe generator.
    initial begin : ticker
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tick = 1'b0;
            if (tick_period != 0) begin
                tcnt++;
                if (tcnt >= tick_period) begin
                    tcnt = 0;
                    tick = 1'b1;
                    last_tick = cyc;
                end
            end else begin
                tcnt = 0;
            end
        end
    end

    // Subordinate model: grant after a stall, respond after a delay.
    task automatic serve();
        logic [31:0] a;
        logic [31:0] w;
        logic        we_c;
        logic [3:0]  b;
        int          st;
        int          dl;
        a = obi_addr; w = obi_wdata; we_c = obi_we; b = obi_be;
        if (!we_c && chk_pace) check("pace_gap", 96'(cyc - last_tick), 96'(1));
        st = we_c ? wr_stall : rd_stall;
        if (st < 0) st = int'($urandom_range(0, 3));
        for (int k = 0; k < st; k++) begin
            @(negedge clk);
            if (!rst_n) return;
        end
        obi_gnt = 1'b1;
        if (st != 0) check("held_stable", 96'({obi_addr, obi_wdata, obi_we, obi_be}), 96'({a, w, we_c, b}));
        @(negedge clk);
        obi_gnt = 1'b0;
        if (!rst_n) return;
        dl = rsp_random ? int'($urandom_range(0, 2)) : 0;
        repeat (dl) @(negedge clk);
        obi_rvalid = 1'b1;
        obi_err    = 1'b0;
        obi_rdata  = $urandom;
        if (!we_c) begin
            obi_rdata = mem_word(salt, rd_idx);
            obi_err   = (err_read >= 0) && (rd_idx == err_read);
            rd_idx++;
        end
    endtask

    initial begin : responder
        obi_gnt = 1'b0; obi_rvalid = 1'b0; obi_rdata = '0; obi_err = 1'b0; obi_rid = '0;
        forever begin
            @(negedge clk);
            obi_gnt = 1'b0; obi_rvalid = 1'b0; obi_err = 1'b0;
            if (late_rsp) begin
                obi_rvalid = 1'b1; obi_err = 1'b1; obi_rdata = 32'hBAD0_BAD0;
                late_rsp = 1'b0;
            end else if (rst_n && obi_req) begin
                serve();
            end
        end
    end

    // Monitor: every granted request must be the next expected transaction.
    initial begin : monitor
        txn_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && obi_req && obi_gnt) begin
                check("txn_expected", 96'(exp_q.size() != 0), 96'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("txn", 96'({obi_we, obi_addr, obi_be, (e.we ? obi_wdata : 32'h0)}),
                          96'({e.we, e.addr, 4'hF, e.data}));
                end
            end
        end
    end

    task automatic run(input logic [31:0] src, input logic [31:0] dst, input logic si, input logic di,
                       input int cnt, input logic pace, input int period, input bit chkp,
                       input int err_idx, input int rds, input int wrs, input bit rsp_rnd,
                       input int exp_lat, input logic exp_ovr, input int poke, input bit done_poke);
        logic [31:0] s;
        logic [31:0] d;
        txn_t        t;
        int          nw;
        int          t0;
        int          k;
        bit          got;
        logic        exp_err;
        @(negedge clk);
        salt = $urandom; rd_idx = 0; err_read = err_idx;
        rd_stall = rds; wr_stall = wrs; rsp_random = rsp_rnd;
        tick_period = period; chk_pace = chkp;
        s = src & ~32'h3; d = dst & ~32'h3; nw = 0;
        for (int i = 0; i < cnt; i++) begin
            t.we = 1'b0; t.addr = s; t.data = 32'h0;
            exp_q.push_back(t);
            if (i == err_idx) break;
            t.we = 1'b1; t.addr = d; t.data = mem_word(salt, i);
            exp_q.push_back(t);
            nw++;
            if (si) s = s + 32'd4;
            if (di) d = d + 32'd4;
        end
        exp_err = (err_idx >= 0) && (err_idx < cnt);
        src_addr = src; dst_addr = dst; src_inc = si; dst_inc = di;
        count = 16'(cnt); pace_en = pace; start = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        check("start_status", 96'({busy, err, overrun, xfer_cnt}), 96'({1'b1, 1'b0, 1'b0, 16'h0}));
        k = 0; got = 0;
        while (k < 3000) begin
            if (done) begin got = 1; break; end
            if (k == poke) begin
                start = 1'b1; src_addr = 32'hDEAD_BEE0; count = 16'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("done_seen", 96'(got), 96'(1));
        if (got) begin
            if (exp_lat >= 0) check("done_latency", 96'(cyc - t0), 96'(exp_lat));
            check("end_status", 96'({busy, err, overrun, xfer_cnt}), 96'({1'b1, exp_err, exp_ovr, 16'(nw)}));
            check("txn_left", 96'(exp_q.size()), 96'(0));
            if (done_poke) begin
                start = 1'b1; count = 16'd5; pace_en = 1'b0;
            end
            @(negedge clk);
            start = 1'b0;
            check("after_done", 96'({busy, done, obi_req}), 96'(0));
            @(negedge clk);
            check("idle_hold", 96'({busy, obi_req}), 96'(0));
        end
        exp_q.delete();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        int c;
        int e;
        start = 1'b0; src_addr = '0; dst_addr = '0; src_inc = 1'b0; dst_inc = 1'b0;
        count = '0; pace_en = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 96'(all_outs), 96'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 96'(all_outs), 96'(0));

        // Unpaced incrementing copy, immediate grant, response next cycle.
        run(32'h2000_0000, 32'h2000_1000, 1, 1, 3, 0, 0, 0, -1, 0, 0, 0, 13, 0, -1, 0);
        // Fixed addresses, paced by a tick every 20 cycles.
        run(32'h3000_1000, 32'h2000_1000, 0, 0, 2, 1, 20, 1, -1, 0, 0, 0, -1, 0, -1, 0);
        // Grant stalls in both request phases.
        run(32'h2000_0100, 32'h2000_2000, 1, 1, 2, 0, 0, 0, -1, 5, 5, 0, -1, 0, -1, 0);
        // Bus error on the second read, then a clean transfer clears the flag.
        run(32'h3000_1000, 32'h2000_2000, 0, 1, 4, 0, 0, 0, 1, 0, 0, 0, -1, 0, -1, 0);
        run(32'h2000_0000, 32'h2000_1000, 1, 0, 2, 0, 0, 0, -1, 0, 0, 0, -1, 0, -1, 0);
        // Several ticks during one word: overrun, transfer still completes.
        run(32'h3000_1000, 32'h2000_1000, 0, 0, 2, 1, 4, 0, -1, 5, 5, 0, -1, 1, -1, 0);
        // Zero count, with a start in the done cycle.
        run(32'h2000_0000, 32'h2000_1000, 1, 1, 0, 0, 0, 0, -1, 0, 0, 0, 1, 0, -1, 1);
        // Start while busy is ignored.
        run(32'h2000_0040, 32'h2000_1040, 1, 1, 3, 0, 0, 0, -1, 0, 0, 0, 13, 0, 3, 0);
        // Address wrap with unaligned inputs.
        run(32'hFFFF_FFFB, 32'h0000_0FFE, 1, 1, 3, 0, 0, 0, -1, 1, 0, 0, -1, 0, -1, 0);

        // Reset while a write request waits for grant.
        @(negedge clk);
        salt = $urandom; rd_idx = 0; err_read = -1; rd_stall = 0; wr_stall = 100000;
        rsp_random = 0; tick_period = 0; chk_pace = 0;
        exp_q.push_back('{we: 1'b0, addr: 32'h2000_0000, data: 32'h0});
        src_addr = 32'h2000_0000; dst_addr = 32'h2000_1000; src_inc = 1; dst_inc = 1;
        count = 16'd2; pace_en = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (c < 50 && !(obi_req && obi_we)) begin
            @(negedge clk);
            c++;
        end
        check("rst_reached_wr_req", 96'(obi_req && obi_we), 96'(1));
        #2 rst_n = 1'b0;
        #1 check("rst_async_outputs", 96'(all_outs), 96'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 late_rsp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_rsp_ignored", 96'({busy, obi_req, done, err, xfer_cnt}), 96'(0));
        end
        wr_stall = 0;

        // Randomized unpaced transfers against the transaction model.
        for (int r = 0; r < 15; r++) begin
            c = int'($urandom_range(1, 5));
            e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, c - 1)) : -1;
            run($urandom, $urandom, 1'($urandom), 1'($urandom), c, 0, 0, 0, e, -1, -1, 1, -1, 0,
                -1, bit'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
